// File: rtl/multi_order_queue_pkg.sv
// multi_order_queue_pkg: op, response and FSM encodings shared by the multi-channel order queue
package multi_order_queue_pkg;
  typedef enum logic [1:0] {PUSH, POP, REMOVE, MODIFY} op_flag_e;
  typedef enum logic [1:0] {OK, OVERFLOW, UNDERFLOW, INVALID} rsp_err_e;
  typedef enum logic {IDLE, SCAN} fsm_state_e;
endpackage

// File: rtl/moq_scan_window.sv
// moq_scan_window: lowest valid offset within the first lim entries of a valid window
module moq_scan_window #(
  parameter int SCAN_SIZE = 4,
  parameter int W = 5
) (
  input  logic [SCAN_SIZE-1:0] win,
  input  logic [W-1:0]         lim,
  output logic [W-1:0]         k,
  output logic                 found
);
  always_comb begin
    k = '0;
    found = 1'b0;
    for (int i = SCAN_SIZE - 1; i >= 0; i--)
      if (win[i] && W'(i) < lim) begin
        k = W'(i);
        found = 1'b1;
      end
  end
endmodule

// File: rtl/multi_order_queue.sv
// multi_order_queue: NUM_CH FIFOs in shared storage with remove/modify by index and a hole-skipping head scan; MOQ_FLUSH_EN adds per-channel flush
module multi_order_queue
  import multi_order_queue_pkg::*;
#(
  parameter int DATA_SIZE = 64,
  parameter int DEPTH = 16,
  parameter int NUM_CH = 4,
  parameter int SCAN_SIZE = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
`ifdef MOQ_FLUSH_EN
  input  logic                           flush_valid,
  input  logic [CH_W-1:0]                flush_ch,
`endif
  input  logic                           op_valid,
  output logic                           op_ready,
  input  logic [1:0]                     op_flag,
  input  logic [CH_W-1:0]                op_ch,
  input  logic [PTR_W-1:0]               op_index,
  input  logic [DATA_SIZE-1:0]           op_data,
  output logic                           rsp_valid,
  output logic [PTR_W-1:0]               rsp_index,
  output logic [DATA_SIZE-1:0]           rsp_data,
  output logic [1:0]                     rsp_err,
  output logic [NUM_CH-1:0]              full,
  output logic [NUM_CH-1:0]              empty,
  output logic [NUM_CH*(PTR_W+1)-1:0]    size
);
  localparam logic [PTR_W:0] SCAN_L = SCAN_SIZE[PTR_W:0];
  logic [PTR_W:0] head [NUM_CH];
  logic [PTR_W:0] tail [NUM_CH];
  logic [PTR_W:0] live [NUM_CH];
  logic [PTR_W:0] cspan [NUM_CH];
  logic [NUM_CH*DEPTH-1:0] vld;
  logic [DATA_SIZE-1:0] mem [NUM_CH*DEPTH];
  fsm_state_e state, state_nx;
  logic [CH_W-1:0] scan_ch, fl_ch;
  logic fl, acc, in_rng, push_ok, pop_ok, rm_ok, md_ok, go_scan, found;
  logic [PTR_W:0] h, t, l, span, sh, sspan, lim, k;
  logic [PTR_W-1:0] off, nh;
  logic [CH_W+PTR_W-1:0] a_idx, a_head, a_tail;
  logic [SCAN_SIZE-1:0] win;
  op_flag_e f;
  rsp_err_e err;

`ifdef MOQ_FLUSH_EN
  assign fl = flush_valid;
  assign fl_ch = flush_ch;
`else
  assign fl = 1'b0;
  assign fl_ch = '0;
`endif

  assign op_ready = state == IDLE && !(fl && fl_ch == op_ch);
  assign acc = op_valid && op_ready;

  always_comb begin
    f = op_flag_e'(op_flag);
    h = head[op_ch];
    t = tail[op_ch];
    l = live[op_ch];
    span = t - h;
    off = op_index - h[PTR_W-1:0];
    nh = h[PTR_W-1:0] + 1;
    a_idx = {op_ch, op_index};
    a_head = {op_ch, h[PTR_W-1:0]};
    a_tail = {op_ch, t[PTR_W-1:0]};
    in_rng = {1'b0, off} < span && vld[a_idx];
    push_ok = f == PUSH && !span[PTR_W];
    pop_ok = f == POP && l != 0;
    rm_ok = f == REMOVE && in_rng;
    md_ok = f == MODIFY && in_rng;
    err = f == PUSH ? (push_ok ? OK : OVERFLOW) : f == POP ? (pop_ok ? OK : UNDERFLOW) : in_rng ? OK : INVALID;
    go_scan = acc && l != 1 && (pop_ok ? !vld[{op_ch, nh}] : rm_ok && op_index == h[PTR_W-1:0]);
    sh = head[scan_ch];
    sspan = tail[scan_ch] - sh;
    lim = sspan < SCAN_L ? sspan : SCAN_L;
    for (int i = 0; i < SCAN_SIZE; i++)
      win[i] = vld[{scan_ch, sh[PTR_W-1:0] + PTR_W'(i)}];
  end

  moq_scan_window #(.SCAN_SIZE(SCAN_SIZE), .W(PTR_W + 1)) u_win (
    .win(win),
    .lim(lim),
    .k(k),
    .found(found)
  );

  always_comb begin
    state_nx = state;
    if (state == SCAN && found) state_nx = IDLE;
    if (go_scan) state_nx = SCAN;
    if (fl && state == SCAN && scan_ch == fl_ch) state_nx = IDLE;
  end

  always_comb
    for (int c = 0; c < NUM_CH; c++) begin
      cspan[c] = tail[c] - head[c];
      full[c] = cspan[c][PTR_W];
      empty[c] = live[c] == 0;
      size[c*(PTR_W+1) +: PTR_W+1] = live[c];
    end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        head[c] <= '0;
        tail[c] <= '0;
        live[c] <= '0;
      end
      vld <= '0;
      state <= IDLE;
      scan_ch <= '0;
      rsp_valid <= 1'b0;
      rsp_index <= '0;
      rsp_data <= '0;
      rsp_err <= '0;
    end else begin
      state <= state_nx;
      rsp_valid <= acc;
      if (acc) begin
        rsp_index <= f == PUSH ? t[PTR_W-1:0] : f == POP ? h[PTR_W-1:0] : op_index;
        rsp_data <= pop_ok ? mem[a_head] : '0;
        rsp_err <= err;
      end
      if (acc && push_ok) begin
        vld[a_tail] <= 1'b1;
        tail[op_ch] <= t + 1;
        live[op_ch] <= l + 1;
      end
      if (acc && (pop_ok || rm_ok)) begin
        vld[pop_ok ? a_head : a_idx] <= 1'b0;
        live[op_ch] <= l - 1;
        head[op_ch] <= l == 1 ? t : pop_ok ? h + 1 : h;
      end
      if (go_scan) scan_ch <= op_ch;
      if (state == SCAN) head[scan_ch] <= sh + (found ? k : lim);
      if (fl) begin
        vld[fl_ch*DEPTH +: DEPTH] <= '0;
        head[fl_ch] <= tail[fl_ch];
        live[fl_ch] <= '0;
      end
    end

  always_ff @(posedge clk)
    if (acc && (push_ok || md_ok)) mem[push_ok ? a_tail : a_idx] <= op_data;
endmodule

// File: tb/tb_multi_order_queue.sv
// tb_multi_order_queue: table-driven ops checked through a response scoreboard, plus scan, reset and flush sequences
module tb_multi_order_queue;
  import multi_order_queue_pkg::*;

  typedef struct {
    logic [1:0]  flag;
    logic        ch;
    logic [2:0]  idx;
    logic [15:0] data;
    logic        chk_idx;
    logic [2:0]  e_idx;
    logic [15:0] e_data;
    logic [1:0]  e_err;
    logic [3:0]  e_size;
  } vec_t;

  logic clk = 0, reset = 1, op_valid = 0, op_ch = 0;
  logic [1:0] op_flag = 0;
  logic [2:0] op_index = 0;
  logic [15:0] op_data = 0;
  logic op_ready, rsp_valid;
  logic [2:0] rsp_index;
  logic [15:0] rsp_data;
  logic [1:0] rsp_err, full, empty;
  logic [7:0] size;
`ifdef MOQ_FLUSH_EN
  logic flush_valid = 0, flush_ch = 0;
`endif
  int total = 0, bad = 0;
  vec_t tbl[$];
  vec_t sb[$];
  vec_t me;

  always #5 clk = ~clk;

  multi_order_queue #(.DATA_SIZE(16), .DEPTH(8), .NUM_CH(2), .SCAN_SIZE(4)) dut (
    .clk(clk),
    .reset(reset),
`ifdef MOQ_FLUSH_EN
    .flush_valid(flush_valid),
    .flush_ch(flush_ch),
`endif
    .op_valid(op_valid),
    .op_ready(op_ready),
    .op_flag(op_flag),
    .op_ch(op_ch),
    .op_index(op_index),
    .op_data(op_data),
    .rsp_valid(rsp_valid),
    .rsp_index(rsp_index),
    .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .full(full),
    .empty(empty),
    .size(size)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t v(logic [1:0] flag, logic ch, logic [2:0] idx, logic [15:0] data,
                             logic chk_idx, logic [2:0] e_idx, logic [15:0] e_data,
                             logic [1:0] e_err, logic [3:0] e_size);
    vec_t r;
    r.flag = flag;
    r.ch = ch;
    r.idx = idx;
    r.data = data;
    r.chk_idx = chk_idx;
    r.e_idx = e_idx;
    r.e_data = e_data;
    r.e_err = e_err;
    r.e_size = e_size;
    return r;
  endfunction

  task automatic op(input vec_t e);
    int n = 0;
    @(negedge clk);
    while (!op_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!op_ready) begin
      total++;
      bad++;
      $display("FAIL op_ready_timeout: op_ready stayed 0 for %0d cycles", n);
    end
    op_flag = e.flag;
    op_ch = e.ch;
    op_index = e.idx;
    op_data = e.data;
    op_valid = 1;
    sb.push_back(e);
    @(posedge clk);
    #1 op_valid = 0;
  endtask

  task automatic run(input int a, input int b);
    for (int i = a; i < b; i++) op(tbl[i]);
  endtask

  task automatic do_reset;
    reset = 1;
    repeat (2) @(negedge clk);
    sb.delete();
    reset = 0;
    #1;
    chk("rst_op_ready", 32'(op_ready), 1);
    chk("rst_empty", 32'(empty), 3);
    chk("rst_full", 32'(full), 0);
    chk("rst_size", 32'(size), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
  endtask

  always @(negedge clk)
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_rsp: rsp_valid=1 with no op outstanding");
      end else begin
        me = sb.pop_front();
        if (me.chk_idx) chk("rsp_index", 32'(rsp_index), 32'(me.e_idx));
        chk("rsp_data", 32'(rsp_data), 32'(me.e_data));
        chk("rsp_err", 32'(rsp_err), 32'(me.e_err));
        chk("size", 32'(size[me.ch*4 +: 4]), 32'(me.e_size));
      end
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, b0, b1, c1, n;
    vec_t pop_scan;
    tbl.push_back(v(PUSH, 0, 0, 16'h00A1, 1, 0, 0, OK, 1));
    tbl.push_back(v(PUSH, 0, 0, 16'h00B2, 1, 1, 0, OK, 2));
    tbl.push_back(v(PUSH, 0, 0, 16'h00C3, 1, 2, 0, OK, 3));
    tbl.push_back(v(POP, 0, 0, 0, 1, 0, 16'h00A1, OK, 2));
    for (int i = 0; i < 8; i++)
      tbl.push_back(v(PUSH, 1, 0, 16'(16'h1100 + i), 1, 3'(i), 0, OK, 4'(i + 1)));
    tbl.push_back(v(PUSH, 1, 0, 16'h11FF, 0, 0, 0, OVERFLOW, 8));
    tbl.push_back(v(POP, 1, 0, 0, 1, 0, 16'h1100, OK, 7));
    tbl.push_back(v(PUSH, 1, 0, 16'h1108, 1, 0, 0, OK, 8));
    tbl.push_back(v(POP, 0, 0, 0, 1, 1, 16'h00B2, OK, 1));
    tbl.push_back(v(POP, 0, 0, 0, 1, 2, 16'h00C3, OK, 0));
    tbl.push_back(v(POP, 0, 0, 0, 0, 0, 0, UNDERFLOW, 0));
    a1 = tbl.size();
    b0 = a1;
    for (int i = 0; i < 8; i++)
      tbl.push_back(v(PUSH, 0, 0, 16'(16'h0200 + i), 1, 3'(i), 0, OK, 4'(i + 1)));
    for (int i = 1; i < 7; i++)
      tbl.push_back(v(REMOVE, 0, 3'(i), 0, 1, 3'(i), 0, OK, 4'(8 - i)));
    b1 = tbl.size();
    tbl.push_back(v(POP, 0, 0, 0, 1, 7, 16'h0207, OK, 0));
    tbl.push_back(v(PUSH, 0, 0, 16'h0E00, 1, 0, 0, OK, 1));
    tbl.push_back(v(PUSH, 0, 0, 16'h0E01, 1, 1, 0, OK, 2));
    tbl.push_back(v(PUSH, 0, 0, 16'h0E02, 1, 2, 0, OK, 3));
    tbl.push_back(v(REMOVE, 0, 5, 0, 1, 5, 0, INVALID, 3));
    tbl.push_back(v(REMOVE, 0, 1, 0, 1, 1, 0, OK, 2));
    tbl.push_back(v(REMOVE, 0, 1, 0, 1, 1, 0, INVALID, 2));
    tbl.push_back(v(MODIFY, 0, 1, 16'hDEAD, 1, 1, 0, INVALID, 2));
    tbl.push_back(v(MODIFY, 0, 2, 16'h0F0F, 1, 2, 0, OK, 2));
    tbl.push_back(v(REMOVE, 0, 0, 0, 1, 0, 0, OK, 1));
    tbl.push_back(v(POP, 0, 0, 0, 1, 2, 16'h0F0F, OK, 0));
    c1 = tbl.size();
    pop_scan = v(POP, 0, 0, 0, 1, 0, 16'h0200, OK, 1);

    do_reset();
    run(0, a1);
    @(negedge clk);
    chk("full_after_fill", 32'(full), 2);
    chk("empty_after_fill", 32'(empty), 1);
    chk("size_after_fill", 32'(size), 32'h80);

    do_reset();
    run(b0, b1);
    op(pop_scan);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (op_ready) break;
      n++;
    end
    chk("scan_cycles", 32'(n), 2);
    run(b1, c1);

    do_reset();
    run(b0, b1);
    op(pop_scan);
    @(negedge clk);
    chk("scan_busy", 32'(op_ready), 0);
    #2 reset = 1;
    #1;
    chk("midscan_rst_ready", 32'(op_ready), 1);
    chk("midscan_rst_empty", 32'(empty), 3);
    @(negedge clk);
    reset = 0;
    sb.delete();

`ifdef MOQ_FLUSH_EN
    run(b0, b1);
    op(pop_scan);
    @(negedge clk);
    flush_valid = 1;
    flush_ch = 0;
    @(posedge clk);
    #1 flush_valid = 0;
    @(negedge clk);
    chk("flush_ready", 32'(op_ready), 1);
    chk("flush_size", 32'(size[3:0]), 0);
    chk("flush_empty", 32'(empty[0]), 1);
    op(v(PUSH, 0, 0, 16'h0A0A, 1, 0, 0, OK, 1));
`endif

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
